// File: rtl/ws_ctrl_pkg.sv
// Shared types for the weight-stationary array controller: FSM state encoding
// and the array fill/drain latency helper.
package ws_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WLOAD,
    STREAM,
    DRAIN,
    DONE
  } ws_state_e;

  // Cycles from an input entering column 0 to its psum leaving the bottom row.
  function automatic int drain_lat(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/ws_valid_delay_line.sv
// Fixed DEPTH-cycle valid delay line with synchronous flush.
// Latency DEPTH cycles; no backpressure, shifts every cycle.
module ws_valid_delay_line #(
  parameter int DEPTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb begin
        sr_d = flush ? 1'b0 : din;
      end
    end else begin : g_multi
      always_comb begin
        sr_d = flush ? '0 : {sr_q[DEPTH-2:0], din};
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/ws_array_controller.sv
// Job sequencer for a weight-stationary PE array: clear, load ROWS weight rows, stream
// cfg_num_vec inputs, drain ROWS+COLS-1 cycles; stalls follow w_valid/if_valid.
module ws_array_controller
  import ws_ctrl_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] cfg_num_vec,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic                 if_valid,
  output logic                 if_ready,
  output logic                 wclr,
  output logic                 iclr,
  output logic [ROWS-1:0]      wload_row,
  output logic                 iload_valid,
  output logic                 psum_capture,
  output logic                 busy,
  output logic                 done,
  output logic                 err_zero_len
);

  localparam int DRAIN_LAT = drain_lat(ROWS, COLS);
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW        = $clog2(DRAIN_LAT + 1);

  ws_state_e            state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CNT_WIDTH-1:0] vec_q, vec_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [DW-1:0]        drn_q, drn_d;
  logic                 clr_q, clr_d;
  logic                 w_ready_q, w_ready_d;
  logic                 if_ready_q, if_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic w_hs;
  logic if_hs;
  logic abort_take;

  assign w_hs       = w_valid & w_ready_q;
  assign if_hs      = if_valid & if_ready_q;
  assign abort_take = abort && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    vec_d   = vec_q;
    num_d   = num_q;
    drn_d   = drn_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_num_vec != '0) begin
            state_d = CLEAR;
            num_d   = cfg_num_vec;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: state_d = WLOAD;
      WLOAD: begin
        if (w_hs) begin
          if (row_q == RW'(ROWS - 1)) begin
            row_d   = '0;
            state_d = STREAM;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      STREAM: begin
        // Compare against the job's latched length; cfg_num_vec may change mid-job.
        if (if_hs) begin
          if (vec_q == num_q - CNT_WIDTH'(1)) begin
            vec_d   = '0;
            state_d = DRAIN;
          end else begin
            vec_d = vec_q + CNT_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (drn_q == DW'(DRAIN_LAT - 1)) begin
          drn_d   = '0;
          state_d = DONE;
        end else begin
          drn_d = drn_q + DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_take) begin
      state_d = IDLE;
      row_d   = '0;
      vec_d   = '0;
      drn_d   = '0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    clr_d      = (state_d == CLEAR) || abort_take;
    w_ready_d  = (state_d == WLOAD);
    if_ready_d = (state_d == STREAM);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      vec_q      <= '0;
      num_q      <= '0;
      drn_q      <= '0;
      clr_q      <= 1'b0;
      w_ready_q  <= 1'b0;
      if_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      vec_q      <= vec_d;
      num_q      <= num_d;
      drn_q      <= drn_d;
      clr_q      <= clr_d;
      w_ready_q  <= w_ready_d;
      if_ready_q <= if_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  ws_valid_delay_line #(
    .DEPTH(DRAIN_LAT)
  ) u_psum_dly (
    .clk  (clk),
    .rst  (rst),
    .flush(abort_take),
    .din  (iload_valid),
    .dout (psum_capture)
  );

  assign w_ready      = w_ready_q;
  assign if_ready     = if_ready_q;
  assign wclr         = clr_q;
  assign iclr         = clr_q;
  assign wload_row    = w_hs ? (ROWS'(1) << row_q) : '0;
  assign iload_valid  = if_hs;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_zero_len = err_q;

endmodule
